matrix_wr_arbiter: RTL

Shares the single matrix-storage write port (element write plus dimension write) among NREQ requesters. Typical requesters are the random matrix generator, the keypad/UART matrix-entry path and the compute-result writer. Ownership is per burst: a requester raises req, receives gnt, streams its writes and drops req to release the port. The block sits between the requesters and the storage module, and all storage-side outputs are registered.

---
 rtl/matrix_wr_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/matrix_wr_arbiter.sv
// matrix_wr_arbiter: round-robin burst arbiter for the shared matrix-storage write port.
// Define ARB_TIMEOUT_EN to forcibly revoke ownership from an owner idle for TIMEOUT cycles.
module matrix_wr_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    output logic [NREQ-1:0]    gnt_o,
    input  logic [2*NREQ-1:0]  slot_i,
    input  logic [3*NREQ-1:0]  row_i,
    input  logic [3*NREQ-1:0]  col_i,
    input  logic [16*NREQ-1:0] data_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [3*NREQ-1:0]  dim_m_i,
    input  logic [3*NREQ-1:0]  dim_n_i,
    input  logic [NREQ-1:0]    dim_we_i,
    output logic [1:0]         mem_slot_o,
    output logic [2:0]         mem_row_o,
    output logic [2:0]         mem_col_o,
    output logic [15:0]        mem_data_o,
    output logic               mem_we_o,
    output logic [2:0]         mem_dim_m_o,
    output logic [2:0]         mem_dim_n_o,
    output logic               mem_dim_we_o,
    output logic [1:0]         owner_o,
    output logic               busy_o,
    input  logic               clr_err_i,
    output logic               drop_err_o,
    output logic               timeout_err_o
);
    typedef enum logic [1:0] {IDLE, OWNED, GAP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick, next_ptr;
    logic [NREQ-1:0]   gnt_q, gnt_d, req_eff, own_mask;
    logic              pick_vld, own, own_req, own_we, own_dim_we, revoke;
    logic [1:0]        mem_slot_q, mem_slot_d;
    logic [2:0]        mem_row_q, mem_row_d, mem_col_q, mem_col_d;
    logic [2:0]        mem_dim_m_q, mem_dim_m_d, mem_dim_n_q, mem_dim_n_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d, mem_dim_we_q, mem_dim_we_d;
    logic              drop_q, drop_d;

    assign own        = state_q == OWNED;
    assign own_req    = req_i[owner_q];
    assign own_we     = we_i[owner_q];
    assign own_dim_we = dim_we_i[owner_q];
    assign own_mask   = own ? NREQ'(1) << owner_q : '0;
    assign next_ptr   = (int'(owner_q) == NREQ - 1) ? 2'd0 : owner_q + 2'd1;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic            to_err_q, to_err_d, own_strobe;
    assign own_strobe    = own_we | own_dim_we;
    assign revoke        = own && own_req && !own_strobe && cnt_q == CW'(TIMEOUT - 1);
    assign cnt_d         = (!own || own_strobe) ? '0 : cnt_q + 1'b1;
    // A revoked requester stays masked until it has been seen with req low.
    assign mask_d        = (mask_q & req_i) | (revoke ? own_mask : '0);
    assign to_err_d      = revoke | (to_err_q & ~clr_err_i);
    assign req_eff       = req_i & ~mask_q;
    assign timeout_err_o = to_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mask_q   <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            to_err_q <= to_err_d;
        end
    end
`else
    assign revoke        = 1'b0;
    assign req_eff       = req_i;
    assign timeout_err_o = 1'b0;
`endif

    // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_eff[(int'(rr_ptr_q) + i) % NREQ]) begin
                pick     = 2'((int'(rr_ptr_q) + i) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            gnt_q        <= '0;
            mem_slot_q   <= '0;
            mem_row_q    <= '0;
            mem_col_q    <= '0;
            mem_data_q   <= '0;
            mem_dim_m_q  <= '0;
            mem_dim_n_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_dim_we_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            mem_slot_q   <= mem_slot_d;
            mem_row_q    <= mem_row_d;
            mem_col_q    <= mem_col_d;
            mem_data_q   <= mem_data_d;
            mem_dim_m_q  <= mem_dim_m_d;
            mem_dim_n_q  <= mem_dim_n_d;
            mem_we_q     <= mem_we_d;
            mem_dim_we_q <= mem_dim_we_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: if (pick_vld) begin
                state_d = OWNED;
                owner_d = pick;
                gnt_d   = NREQ'(1) << pick;
            end
            OWNED: if (!own_req || revoke) begin
                state_d  = GAP;
                gnt_d    = '0;
                rr_ptr_d = next_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we_d     = own & own_we & own_req;
        mem_dim_we_d = own & own_dim_we & own_req;
        mem_slot_d   = own ? slot_i[2*int'(owner_q) +: 2] : mem_slot_q;
        mem_row_d    = own ? row_i[3*int'(owner_q) +: 3] : mem_row_q;
        mem_col_d    = own ? col_i[3*int'(owner_q) +: 3] : mem_col_q;
        mem_data_d   = own ? data_i[16*int'(owner_q) +: 16] : mem_data_q;
        mem_dim_m_d  = own ? dim_m_i[3*int'(owner_q) +: 3] : mem_dim_m_q;
        mem_dim_n_d  = own ? dim_n_i[3*int'(owner_q) +: 3] : mem_dim_n_q;
        drop_d       = (|((we_i | dim_we_i) & ~own_mask)) | (drop_q & ~clr_err_i);
    end

    assign gnt_o        = gnt_q;
    assign owner_o      = owner_q;
    assign busy_o       = own;
    assign mem_slot_o   = mem_slot_q;
    assign mem_row_o    = mem_row_q;
    assign mem_col_o    = mem_col_q;
    assign mem_data_o   = mem_data_q;
    assign mem_dim_m_o  = mem_dim_m_q;
    assign mem_dim_n_o  = mem_dim_n_q;
    assign mem_we_o     = mem_we_q;
    assign mem_dim_we_o = mem_dim_we_q;
    assign drop_err_o   = drop_q;
endmodule
